// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions, issuer FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

    // ALUControl encodings understood by the result mux; 1001..1111 are illegal.
    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SLR = 4'b0110,
        OP_SAR = 4'b0111,
        OP_SC  = 4'b1000
    } alu_op_t;

    // Bit positions inside the 4-bit {N,Z,C,V} flag word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag word returned for a rejected opcode: only Z set, matching the zero result.
    localparam logic [3:0] ILLEGAL_FLAGS = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issuer_state_t;

    // Legal opcodes are the contiguous range 0000..1000.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_SC);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// NZCV flag derivation from an ALU result, its opcode and the adder status bits.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: y (result), op (ALUControl), carry / overflow (adder status) -> flags {N,Z,C,V}.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] y,
    input  logic [3:0]   op,
    input  logic         carry,
    input  logic         overflow,
    output logic [3:0]   flags
);

    logic is_arith;

    // Carry and overflow only mean something for the adder paths.
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = y[N-1];
        flags[FLAG_Z] = (y == '0);
        flags[FLAG_C] = is_arith & carry;
        flags[FLAG_V] = is_arith & overflow;
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Accepts an ALU request, registers operands/select, captures the result with NZCV flags.
// Latency: legal op -> rsp_valid 2 cycles after accept; illegal op -> 1 cycle.
// Backpressure: cmd_ready low until the response handshakes; response held while rsp_ready is low.
// Ports: cmd_* request in, alu_a/alu_b/ALUControl out to ALU, alu_y/alu_carry/alu_overflow back,
//        rsp_* response out, op_count = completed responses (wraps).
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       ALUControl,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    issuer_state_t state, state_nxt;
    logic [3:0]    issue_flags;
    logic          cmd_legal;

    assign cmd_legal = op_is_legal(cmd_op);

    // Flags are taken from the registered select, i.e. the op the ALU is currently computing.
    alu_flag_gen #(.N(N)) u_flag_gen (
        .y        (alu_y),
        .op       (ALUControl),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .flags    (issue_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Illegal ops skip the ALU entirely and answer one cycle sooner.
                    state_nxt = cmd_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ALU-side registers keep their last issued value outside ISSUE; they are never cleared
    // except by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            ALUControl <= 4'b0000;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            alu_a      <= cmd_a;
                            alu_b      <= cmd_b;
                            ALUControl <= cmd_op;
                        end else begin
                            rsp_y     <= '0;
                            rsp_flags <= ILLEGAL_FLAGS;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= issue_flags;
                    rsp_err   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer with a transaction-level reference model.
// Latency: n/a.
// Backpressure: bench drives rsp_ready low for chosen stall lengths.
module tb_alu_op_issuer;

    localparam int N     = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [N-1:0]     cmd_a;
    logic [N-1:0]     cmd_b;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       ALUControl;
    logic [N-1:0]     alu_y;
    logic             alu_carry;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_y;
    logic [3:0]       rsp_flags;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: completed count and the select the ALU should be holding.
    int         exp_count = 0;
    logic [3:0] last_ctrl = 4'b0000;
    int         wraps     = 0;

    alu_op_issuer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .ALUControl   (ALUControl),
        .alu_y        (alu_y),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for one command, straight from the opcode/flag rules.
    function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [N-1:0] y,
                                               input logic c, input logic v);
        logic addsub;
        if (op > 4'd8) return 4'b0100;
        addsub = (op == 4'd0) || (op == 4'd1);
        return {y[N-1], (y == 0), addsub & c, addsub & v};
    endfunction

    // Runs one command from IDLE through the response handshake. If preload is set, the next
    // command is presented during the stall so it can only be taken after the handshake.
    task automatic do_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] y, input logic c, input logic v, input int stall,
                         input logic preload, input logic [3:0] nop,
                         input logic [N-1:0] na, input logic [N-1:0] nb);
        logic       legal;
        logic [N-1:0] ey;
        logic [3:0] ef;
        legal = (op <= 4'd8);
        ey    = legal ? y : '0;
        ef    = model_flags(op, y, c, v);
        chk("ready_before_accept", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_a        = a;
        cmd_b        = b;
        alu_y        = y;
        alu_carry    = c;
        alu_overflow = v;
        rsp_ready    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        if (legal) begin
            chk("issue_no_rsp", rsp_valid, 0);
            chk("issue_ready_low", cmd_ready, 0);
            chk("issue_ctrl", ALUControl, op);
            chk("issue_a", alu_a, a);
            chk("issue_b", alu_b, b);
            last_ctrl = op;
            tick();
        end else begin
            chk("illegal_ctrl_held", ALUControl, last_ctrl);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_ready_low", cmd_ready, 0);
        chk("rsp_y", rsp_y, ey);
        chk("rsp_flags", rsp_flags, ef);
        chk("rsp_err", rsp_err, !legal);
        if (preload) begin
            cmd_valid = 1'b1;
            cmd_op    = nop;
            cmd_a     = na;
            cmd_b     = nb;
        end
        for (int i = 0; i < stall; i++) begin
            // Disturb the ALU inputs: the captured response must not follow them.
            alu_y        = N'($urandom);
            alu_carry    = 1'($urandom);
            alu_overflow = 1'($urandom);
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_ready_low", cmd_ready, 0);
            chk("stall_y", rsp_y, ey);
            chk("stall_flags", rsp_flags, ef);
            chk("stall_err", rsp_err, !legal);
            chk("stall_ctrl", ALUControl, last_ctrl);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        if (exp_count == 0) wraps++;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_ready", cmd_ready, 1);
        chk("op_count", op_count, exp_count);
        if (preload) begin
            // Held command is visible but not yet consumed.
            chk("preload_not_taken", ALUControl, last_ctrl);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_a        = '0;
        cmd_b        = '0;
        alu_y        = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        rsp_ready    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ctrl", ALUControl, 0);
        chk("rst_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_err", rsp_err, 0);

        // Reset during ISSUE discards the operation.
        cmd_valid = 1'b1;
        cmd_op    = 4'b0010;
        cmd_a     = 3'b111;
        cmd_b     = 3'b101;
        alu_y     = 3'b101;
        tick();
        cmd_valid = 1'b0;
        chk("midrst_in_issue", cmd_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_idle", cmd_ready, 1);
        chk("midrst_no_rsp", rsp_valid, 0);
        chk("midrst_count", op_count, exp_count);
        chk("midrst_ctrl", ALUControl, 0);
        tick();
        chk("midrst_no_rsp_later", rsp_valid, 0);
        last_ctrl = 4'b0000;

        // Directed: add with carry, xor with masked carry, illegal op.
        do_op(4'b0000, 3'b011, 3'b101, 3'b000, 1'b1, 1'b0, 0, 1'b0, 4'h0, '0, '0);
        do_op(4'b0100, 3'b110, 3'b011, 3'b101, 1'b1, 1'b0, 0, 1'b0, 4'h0, '0, '0);
        do_op(4'b1011, 3'b010, 3'b001, 3'b111, 1'b1, 1'b1, 0, 1'b0, 4'h0, '0, '0);

        // Backpressure: 10-cycle stall with the next command already held.
        do_op(4'b0001, 3'b001, 3'b010, 3'b111, 1'b0, 1'b1, 10, 1'b1, 4'b0011, 3'b100, 3'b001);
        do_op(4'b0011, 3'b100, 3'b001, 3'b101, 1'b1, 1'b1, 0, 1'b0, 4'h0, '0, '0);

        // Randomized commands, enough to wrap the counter.
        for (int k = 0; k < 256; k++) begin
            do_op(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), N'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0, 4'h0, '0, '0);
        end
        chk("count_wrapped", (wraps > 0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Command-side initiator for the ALU result multiplexer. It accepts an operation request over a valid/ready handshake, registers the operands, and drives the 4-bit ALUControl select and operands to the ALU datapath.
- It then captures the selected result, derives NZCV flags, and returns a response over a second valid/ready handshake.
- It sits between the lab top-level (switch/button front end) and the combinational ALU.

Parameters:
N, 3, operand/result width in bits (N >= 2)
CNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  request present
cmd_ready  output  1  block can accept request
cmd_op  input  4  requested operation, ALUControl encoding
cmd_a  input  N  operand A
cmd_b  input  N  operand B
alu_a  output  N  registered operand A to ALU
alu_b  output  N  registered operand B to ALU
ALUControl  output  4  registered ALU select
alu_y  input  N  ALU result (mux output y), combinational from alu_a/alu_b/ALUControl
alu_carry  input  1  adder carry-out
alu_overflow  input  1  adder signed overflow
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_y  output  N  captured result
rsp_flags  output  4  {N,Z,C,V}
rsp_err  output  1  illegal opcode
op_count  output  CNT_W  completed responses, wraps

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values:
    - state=IDLE, cmd_ready=1, rsp_valid=0.
    - rsp_y, rsp_flags, rsp_err, alu_a, alu_b, op_count all 0.
    - ALUControl=4'b0000.
- Legal opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 slr, 0111 sar, 1000 sc.
  - 1001..1111 are illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready with a legal op: load alu_a<=cmd_a, alu_b<=cmd_b, ALUControl<=cmd_op; go to ISSUE.
  - On an illegal op: do not touch alu_a/alu_b/ALUControl; load rsp_y<=0, rsp_flags<=4'b0100, rsp_err<=1; go to RESP.
- ISSUE:
  - Lasts exactly one cycle. cmd_ready=0.
  - At the end of the cycle, capture rsp_y<=alu_y and rsp_err<=0, set flags, and go to RESP.
- Flag rules:
  - N = alu_y[N-1].
  - Z = (alu_y==0).
  - C = alu_carry if op is 0000/0001, else 0.
  - V = alu_overflow if op is 0000/0001, else 0.
- RESP:
  - rsp_valid=1, cmd_ready=0.
  - rsp_y, rsp_flags and rsp_err stay stable until the handshake.
  - On rsp_valid&&rsp_ready: op_count<=op_count+1 (wraps from all-ones to 0); go to IDLE.
- Latency:
  - Legal op accepted at edge t: rsp_valid is high after edge t+2.
  - Illegal op: rsp_valid is high after edge t+1.
- Throughput: at most one command per 3 cycles. cmd_ready is low in ISSUE and RESP, so no same-cycle response and accept.
- ALUControl, alu_a and alu_b hold their last issued values in IDLE and RESP. They are not cleared.
- A response stalled by rsp_ready=0 is held indefinitely; no timeout.
- cmd_valid with cmd_ready=0 is ignored; the requester must keep it held.
- rst asserted in any state forces the reset values on the next edge. Any in-flight operation is discarded and op_count is not incremented.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_t with the nine legal encodings above, shared with the result mux and ALU top.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state typedef.
- One sub-module is natural: alu_flag_gen, a combinational unit taking y, op, carry and overflow and producing the 4-bit flags. It is reused by the ALU top for status LEDs.

Test Plan:
- Reset, N=3: after rst is held 2 cycles, check cmd_ready=1, rsp_valid=0, ALUControl=0000, op_count=0.
- Add, N=3: op=0000, a=3'b011, b=3'b101, ALU returns y=000, carry=1, overflow=0. Required: rsp_valid at t+2, rsp_y=000, flags=4'b0110, err=0, op_count=1 after handshake.
- XOR: op=0100, a=110, b=011, alu_y=101 with carry forced to 1. Required: ALUControl=0100 during ISSUE, rsp_y=101, flags=4'b1000 (C masked).
- Illegal op: op=1011. Required: rsp_valid at t+1, rsp_err=1, rsp_y=0, flags=0100, ALUControl unchanged from the previous op.
- Backpressure: hold rsp_ready=0 for 10 cycles while cmd_valid=1 with a new op. Required: outputs stable, cmd_ready=0 throughout, second op accepted only in the cycle after the handshake.
- Mid-operation reset and wrap:
  - Assert rst during ISSUE. Required: IDLE next cycle, no response, op_count unchanged.
  - Run 256 ops. Required: op_count wraps to 0.
